// File: rtl/demux_ctrl_pkg.sv
// Shared definitions for the demux sequencer: state encoding, destination field
// position and destination count.
package demux_ctrl_pkg;

    localparam int unsigned NUM_DEST       = 4;
    localparam int unsigned DEST_BITS      = 2;
    localparam int unsigned DEMUX_SEL_BITS = 2;

    typedef enum logic [2:0] {
        ST_RESET  = 3'd0,
        ST_INIT   = 3'd1,
        ST_IDLE   = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_ERROR  = 3'd4
    } state_t;

    // Destination lives in the two top bits of every word.
    function automatic int unsigned dest_msb(input int unsigned data_bits);
        return data_bits - 1;
    endfunction

    function automatic int unsigned dest_lsb(input int unsigned data_bits);
        return data_bits - DEST_BITS;
    endfunction

endpackage

// File: rtl/demux_ctrl_demux.sv
// 1-to-4 demux output stage: routes data to the selected output when enabled,
// all outputs are zero otherwise.
module demux_ctrl_demux #(
    parameter int unsigned DATA_BITS = 6,
    parameter int unsigned SEL_BITS  = 2
) (
    input  logic                 enb,
    input  logic [SEL_BITS-1:0]  sel,
    input  logic [DATA_BITS-1:0] data,
    output logic [DATA_BITS-1:0] salida0,
    output logic [DATA_BITS-1:0] salida1,
    output logic [DATA_BITS-1:0] salida2,
    output logic [DATA_BITS-1:0] salida3
);

    always_comb begin
        salida0 = '0;
        salida1 = '0;
        salida2 = '0;
        salida3 = '0;
        if (enb) begin
            case (sel)
                SEL_BITS'(0): salida0 = data;
                SEL_BITS'(1): salida1 = data;
                SEL_BITS'(2): salida2 = data;
                SEL_BITS'(3): salida3 = data;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/demux_ctrl.sv
// Drains the source FIFO into four destination FIFOs through the demux stage,
// with per-destination push counters, idle and sticky overflow flags.
module demux_ctrl
    import demux_ctrl_pkg::*;
#(
    parameter int unsigned DATA_BITS = 6,
    parameter int unsigned CNT_BITS  = 8
) (
    input  logic                 clk,
    input  logic                 reset_L,
    input  logic                 init,
    input  logic                 fifo_empty,
    input  logic [DATA_BITS-1:0] fifo_data,
    input  logic [NUM_DEST-1:0]  almost_full,
    input  logic [NUM_DEST-1:0]  full,
    output logic                 fifo_pop,
    output logic [NUM_DEST-1:0]  push,
    output logic [DATA_BITS-1:0] salida0,
    output logic [DATA_BITS-1:0] salida1,
    output logic [DATA_BITS-1:0] salida2,
    output logic [DATA_BITS-1:0] salida3,
    output logic                 idle,
    output logic                 error,
    output logic [CNT_BITS-1:0]  cnt0,
    output logic [CNT_BITS-1:0]  cnt1,
    output logic [CNT_BITS-1:0]  cnt2,
    output logic [CNT_BITS-1:0]  cnt3
);

    localparam int unsigned DEST_MSB = dest_msb(DATA_BITS);
    localparam int unsigned DEST_LSB = dest_lsb(DATA_BITS);

    state_t                 state;
    state_t                 next_state;
    logic [DEST_BITS-1:0]   dest;
    logic                   can_pop;
    logic                   overflow;
    logic [NUM_DEST-1:0]    push_d;

    logic                   enb;
    logic [DEST_BITS-1:0]   sel;
    logic [DATA_BITS-1:0]   data;
    logic [CNT_BITS-1:0]    cnt_q [NUM_DEST];

    assign dest     = fifo_data[DEST_MSB:DEST_LSB];
    assign overflow = |(push & full);

    // State register
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state <= ST_RESET;
        end else begin
            state <= next_state;
        end
    end

    // Next state and combinational pop; an overflow outranks a concurrent init
    always_comb begin
        next_state = state;
        fifo_pop   = 1'b0;
        can_pop    = !init && !fifo_empty && !almost_full[dest];
        push_d     = '0;
        push_d[dest] = 1'b1;
        case (state)
            ST_RESET: next_state = ST_INIT;
            ST_INIT: begin
                if (!init) next_state = ST_IDLE;
            end
            ST_IDLE: begin
                fifo_pop = can_pop;
                if (overflow)        next_state = ST_ERROR;
                else if (init)       next_state = ST_INIT;
                else if (!fifo_empty) next_state = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                fifo_pop = can_pop;
                if (overflow)                     next_state = ST_ERROR;
                else if (init)                    next_state = ST_INIT;
                else if (fifo_empty && push == '0) next_state = ST_IDLE;
            end
            ST_ERROR: begin
                if (init) next_state = ST_INIT;
            end
            default: next_state = ST_RESET;
        endcase
    end

    // Output stage feeding the demux; data and sel hold between pops
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            enb  <= 1'b0;
            sel  <= '0;
            data <= '0;
            push <= '0;
        end else begin
            enb  <= fifo_pop;
            push <= fifo_pop ? push_d : '0;
            if (fifo_pop) begin
                sel  <= dest;
                data <= fifo_data;
            end
        end
    end

    // Counters, sticky error and idle flag
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            for (int unsigned d = 0; d < NUM_DEST; d++) cnt_q[d] <= '0;
            error <= 1'b0;
            idle  <= 1'b0;
        end else begin
            if (state == ST_INIT) begin
                for (int unsigned d = 0; d < NUM_DEST; d++) cnt_q[d] <= '0;
                error <= 1'b0;
            end else begin
                for (int unsigned d = 0; d < NUM_DEST; d++) begin
                    if (push[d]) cnt_q[d] <= cnt_q[d] + CNT_BITS'(1);
                end
                if (overflow && (state == ST_IDLE || state == ST_ACTIVE)) error <= 1'b1;
            end
            idle <= (state == ST_IDLE) && (next_state == ST_IDLE) && !fifo_pop;
        end
    end

    assign cnt0 = cnt_q[0];
    assign cnt1 = cnt_q[1];
    assign cnt2 = cnt_q[2];
    assign cnt3 = cnt_q[3];

    demux_ctrl_demux #(
        .DATA_BITS (DATA_BITS),
        .SEL_BITS  (DEMUX_SEL_BITS)
    ) u_demux (
        .enb     (enb),
        .sel     (DEMUX_SEL_BITS'(sel)),
        .data    (data),
        .salida0 (salida0),
        .salida1 (salida1),
        .salida2 (salida2),
        .salida3 (salida3)
    );

endmodule

// File: tb/tb_demux_ctrl.sv
// Self-checking bench for demux_ctrl: directed scenarios plus random traffic
// compared against a queue-based behavioural model.
module tb_demux_ctrl;

    localparam int DW = 6;
    localparam int CW = 8;

    localparam int M_RST  = 0;
    localparam int M_INIT = 1;
    localparam int M_RUN  = 2;
    localparam int M_HALT = 3;

    logic          clk = 1'b0;
    logic          reset_L;
    logic          init;
    logic          fifo_empty;
    logic [DW-1:0] fifo_data;
    logic [3:0]    almost_full;
    logic [3:0]    full;
    logic          fifo_pop;
    logic [3:0]    push;
    logic [DW-1:0] salida0, salida1, salida2, salida3;
    logic          idle;
    logic          error;
    logic [CW-1:0] cnt0, cnt1, cnt2, cnt3;

    demux_ctrl #(.DATA_BITS(DW), .CNT_BITS(CW)) dut (
        .clk         (clk),
        .reset_L     (reset_L),
        .init        (init),
        .fifo_empty  (fifo_empty),
        .fifo_data   (fifo_data),
        .almost_full (almost_full),
        .full        (full),
        .fifo_pop    (fifo_pop),
        .push        (push),
        .salida0     (salida0),
        .salida1     (salida1),
        .salida2     (salida2),
        .salida3     (salida3),
        .idle        (idle),
        .error       (error),
        .cnt0        (cnt0),
        .cnt1        (cnt1),
        .cnt2        (cnt2),
        .cnt3        (cnt3)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model state
    logic [DW-1:0] src_q[$];
    int            mode;
    logic          pop_exp;
    logic [3:0]    exp_push;
    logic          exp_enb;
    logic [1:0]    exp_sel;
    logic [DW-1:0] exp_data;
    logic [CW-1:0] exp_cnt [4];
    logic          exp_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] exp_sal(input int i);
        return (exp_enb && exp_sel == 2'(i)) ? exp_data : '0;
    endfunction

    task automatic model_reset();
        mode     = M_RST;
        pop_exp  = 1'b0;
        exp_push = '0;
        exp_enb  = 1'b0;
        exp_sel  = '0;
        exp_data = '0;
        exp_err  = 1'b0;
        for (int i = 0; i < 4; i++) exp_cnt[i] = '0;
    endtask

    task automatic apply_src();
        if (src_q.size() > 0) begin
            fifo_empty = 1'b0;
            fifo_data  = src_q[0];
        end else begin
            fifo_empty = 1'b1;
            fifo_data  = DW'($urandom);
        end
    endtask

    task automatic check_outputs();
        check("fifo_pop", 32'(fifo_pop), 32'(pop_exp));
        check("push",     32'(push),     32'(exp_push));
        check("salida0",  32'(salida0),  32'(exp_sal(0)));
        check("salida1",  32'(salida1),  32'(exp_sal(1)));
        check("salida2",  32'(salida2),  32'(exp_sal(2)));
        check("salida3",  32'(salida3),  32'(exp_sal(3)));
        check("cnt0",     32'(cnt0),     32'(exp_cnt[0]));
        check("cnt1",     32'(cnt1),     32'(exp_cnt[1]));
        check("cnt2",     32'(cnt2),     32'(exp_cnt[2]));
        check("cnt3",     32'(cnt3),     32'(exp_cnt[3]));
        check("error",    32'(error),    32'(exp_err));
    endtask

    // One clock: present source head, compare, then advance the model at the edge
    task automatic step();
        logic [1:0] d;
        logic       ovf;
        apply_src();
        pop_exp = (mode == M_RUN) && !init && (src_q.size() > 0) &&
                  !almost_full[src_q[0][DW-1:DW-2]];
        #1 check_outputs();
        @(posedge clk);
        ovf = |(exp_push & full);
        if (mode == M_INIT) begin
            for (int i = 0; i < 4; i++) exp_cnt[i] = '0;
            exp_err = 1'b0;
        end else begin
            for (int i = 0; i < 4; i++)
                if (exp_push[i]) exp_cnt[i] = exp_cnt[i] + 8'd1;
            if (mode == M_RUN && ovf) exp_err = 1'b1;
        end
        if (pop_exp) begin
            d        = src_q[0][DW-1:DW-2];
            exp_push = 4'b0001 << d;
            exp_enb  = 1'b1;
            exp_sel  = d;
            exp_data = src_q.pop_front();
        end else begin
            exp_push = '0;
            exp_enb  = 1'b0;
        end
        case (mode)
            M_RST:  mode = M_INIT;
            M_INIT: if (!init) mode = M_RUN;
            M_RUN:  if (ovf) mode = M_HALT; else if (init) mode = M_INIT;
            M_HALT: if (init) mode = M_INIT;
            default: mode = M_RST;
        endcase
        @(negedge clk);
    endtask

    task automatic async_reset(input int hold);
        #2 reset_L = 1'b0;
        model_reset();
        #1 check_outputs();
        check("idle_in_reset", 32'(idle), 32'(0));
        repeat (hold) @(negedge clk);
        reset_L = 1'b1;
    endtask

    task automatic init_pulse();
        init = 1'b1;
        step();
        step();
        init = 1'b0;
        step();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [DW-1:0] w;
        reset_L     = 1'b0;
        init        = 1'b1;
        almost_full = '0;
        full        = '0;
        model_reset();
        apply_src();
        #1 check_outputs();
        check("idle_reset", 32'(idle), 32'(0));
        @(negedge clk);
        @(negedge clk);
        reset_L = 1'b1;

        // Reset release and init pulse; idle two cycles after init falls
        step();
        step();
        init = 1'b0;
        step();
        check("idle_one_after_init", 32'(idle), 32'(0));
        step();
        check("idle_two_after_init", 32'(idle), 32'(1));

        // One word to each destination, back to back
        src_q = '{6'h05, 6'h1A, 6'h2F, 6'h3C};
        step();
        check("idle_streaming", 32'(idle), 32'(0));
        repeat (3) step();
        repeat (5) step();
        check("burst_cnt0", 32'(cnt0), 32'(1));
        check("burst_cnt3", 32'(cnt3), 32'(1));
        check("idle_after_burst", 32'(idle), 32'(1));

        // almost_full stall on destination 2
        almost_full = 4'b0100;
        src_q.push_back(6'h2F);
        repeat (3) step();
        almost_full = '0;
        step();
        check("af_release_push", 32'(push), 32'(4'b0100));
        repeat (4) step();

        // Overflow on destination 1, then recovery through init
        src_q.push_back(6'h1A);
        step();
        full = 4'b0010;
        step();
        full = '0;
        check("err_rise", 32'(error), 32'(1));
        src_q.push_back(6'h05);
        repeat (3) step();
        init = 1'b1;
        step();
        step();
        init = 1'b0;
        check("err_cleared", 32'(error), 32'(0));
        check("cnt1_cleared", 32'(cnt1), 32'(0));
        repeat (6) step();

        // 256 words to destination 3: counter wraps
        init_pulse();
        for (int i = 0; i < 256; i++) begin
            w = DW'($urandom);
            w[DW-1:DW-2] = 2'b11;
            src_q.push_back(w);
        end
        repeat (262) step();
        check("wrap_cnt3", 32'(cnt3), 32'(0));
        check("wrap_cnt0", 32'(cnt0), 32'(0));
        check("wrap_cnt2", 32'(cnt2), 32'(0));

        // Random traffic with random almost_full stalls
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 2) != 0 && src_q.size() < 16)
                src_q.push_back(DW'($urandom));
            almost_full = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
            step();
        end
        almost_full = '0;
        for (int i = 0; i < 40 && src_q.size() > 0; i++) step();
        repeat (4) step();
        check("idle_after_random", 32'(idle), 32'(1));

        // Asynchronous reset in the middle of a burst
        for (int i = 0; i < 10; i++) src_q.push_back(DW'($urandom));
        repeat (3) step();
        async_reset(2);
        repeat (15) step();
        check("idle_after_reset_burst", 32'(idle), 32'(1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/demux_ctrl.md
# demux_ctrl

Sequencer that drains a single input FIFO and steers each word through the 1-to-4 demux into one of four destination FIFOs. Each word carries its 2-bit destination in its top bits. The block pops the source only when the target FIFO can accept, registers the word, and drives the demux and the per-destination push strobes. It also keeps per-destination push counters and flags idle and overflow conditions for the upper-level control.

## Interface
Parameters:
- DATA_BITS, 6, word width; destination field = entrada[DATA_BITS-1:DATA_BITS-2]
- CNT_BITS, 8, width of each per-destination push counter

Ports:
- clk  in  1  single clock, rising edge
- reset_L  in  1  asynchronous, active-low reset
- init  in  1  while high, hold in INIT and clear counters and error
- fifo_empty  in  1  source FIFO empty
- fifo_data  in  DATA_BITS  source FIFO head word, valid whenever fifo_empty=0
- almost_full  in  4  per-destination almost-full, bit i = destination i
- full  in  4  per-destination full
- fifo_pop  out  1  pop source FIFO; combinational; consumed at the same rising edge
- push  out  4  one-hot push to destination FIFO, registered
- salida0..salida3  out  DATA_BITS each  per-destination data from the demux stage
- idle  out  1  no word pending and none in flight, registered
- error  out  1  sticky overflow flag, registered
- cnt0..cnt3  out  CNT_BITS each  pushes issued per destination, registered

## Operation
- States:
  - RESET: while reset_L=0, and for the first edge after release.
  - INIT: clear counters and error; no pops.
  - IDLE: source empty, nothing in flight; idle=1.
  - ACTIVE: forwarding words.
  - ERROR: overflow occurred; no pops.
- Transitions:
  - RESET→INIT unconditionally.
  - INIT→IDLE when init=0.
  - IDLE→ACTIVE when fifo_empty=0.
  - ACTIVE→IDLE when fifo_empty=1 and push=0.
  - Any of IDLE/ACTIVE→ERROR when push[d]=1 and full[d]=1 in the same cycle.
  - ERROR→INIT when init=1.
  - init=1 in IDLE or ACTIVE→INIT; an in-flight word still completes its push.
- Pop condition, evaluated combinationally: fifo_pop = (state∈{IDLE,ACTIVE}) & init=0 & fifo_empty=0 & almost_full[dest]=0, where dest = fifo_data[DATA_BITS-1:DATA_BITS-2].
- A blocked destination stalls the whole stream (in-order, no bypass).
- On a pop edge the output stage registers: enb=1, sel=dest, data=fifo_data, push=onehot(dest). Otherwise enb=0 and push=0; data and sel hold.
- Demux outputs: salida[sel]=data when enb=1; all salidas are 0 otherwise.
- Counters: cnt[d] increments on each cycle with push[d]=1; wraps 2^CNT_BITS-1→0. Cleared in INIT.
- In ERROR, the offending word is still presented; the destination FIFO drops it. error stays 1 until INIT.

## Timing
- Reset values (asynchronous, immediate): fifo_pop=0, push=0, salida0..3=0, idle=0, error=0, cnt0..3=0, state=RESET.
- Latency: pop in cycle N → push/salida valid in cycle N+1.
- Throughput: 1 word per cycle sustained.
- Destination almost_full thresholds must leave at least 1 free slot to absorb the in-flight word.
- idle=1 the cycle after IDLE is entered; 0 in all other states.
- error rises the cycle after the overflowing push.
- reset_L low mid-transfer: the in-flight word is discarded and all outputs go to reset values immediately.

## Structure
- Shared package holds: state encoding constants, the destination field position (DATA_BITS-1:DATA_BITS-2), and NUM_DEST=4.
- One sub-module: the team's existing demux block as the output stage. Instantiate it with the same DATA_BITS, driven by registered enb, data and sel, with sel zero-extended to the demux selector width.

## Test plan
- Reset, then init pulse → outputs all 0; state reaches IDLE; idle=1 two cycles after init falls.
- Source holds 0x05, 0x1A, 0x2F, 0x3C (dest 0,1,2,3) → fifo_pop 4 consecutive cycles. push = 0001, 0010, 0100, 1000 one cycle later, with salida0=0x05, salida1=0x1A, salida2=0x2F, salida3=0x3C. Each cnt = 1; idle returns.
- almost_full[2]=1 with head 0x2F → fifo_pop=0 and push=0 while asserted. Deassert → pop the same cycle, push[2] next cycle.
- Force full[1]=1 while push[1]=1 → error=1 next cycle, pops stop. init pulse → error=0, cnt cleared.
- 256 words to dest 3 → cnt3 wraps to 0; cnt0..cnt2 stay 0.
- reset_L low during a streaming burst → push and salidas go to 0 immediately; after release the sequence restarts from RESET→INIT.
